uart_tx_p: RTL and testbench

Parametrised UART transmitter, next generation of the fixed 8n1 transmitter. Word length, parity mode, stop-bit count and clocks-per-bit are configurable. The block runs from the system clock through an internal bit-rate divider instead of a dedicated bit-rate clock. It keeps the data_rdy/fetch handshake used with the external FIFO, adds back-to-back framing and a busy flag, and sits between a FIFO read port and a physical TX pin.

---
 rtl/uart_tx_p_if.sv | 35 +++
 rtl/uart_tx_p.sv | 218 +++++++++++++++++++++
 tb/tb_uart_tx_p.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_p_if.sv
// ---------------------------------------------------------------------------
// uart_tx_p_if
// FIFO read-port handshake between an external FIFO and the uart_tx_p
// transmitter.
//
// Signals:
//   data_rdy : FIFO -> TX  high while data holds a word ready to send
//   data     : FIFO -> TX  word to transmit (DBITS wide)
//   fetch    : TX -> FIFO  one-cycle pulse, the word on data was consumed
//
// Modports:
//   master : FIFO side (drives data_rdy/data, observes fetch)
//   slave  : transmitter side (observes data_rdy/data, drives fetch)
// ---------------------------------------------------------------------------
interface uart_tx_p_if #(
    parameter int DBITS = 8
) ();

    logic             data_rdy;
    logic [DBITS-1:0] data;
    logic             fetch;

    modport master (
        output data_rdy,
        output data,
        input  fetch
    );

    modport slave (
        input  data_rdy,
        input  data,
        output fetch
    );

endinterface

// File: rtl/uart_tx_p.sv
// ---------------------------------------------------------------------------
// uart_tx_p
// Parametrised UART transmitter. Pulls words from an external FIFO through
// the data_rdy/fetch handshake and serialises them LSB first onto a single
// idle-high line: start bit, DBITS data bits, optional parity bit, SBITS stop
// bits. Every bit is held for DIV cycles of the system clock. When a word is
// waiting at the end of the last stop bit, the next start bit follows
// immediately with no idle gap.
//
// Parameters:
//   DBITS  : data bits per frame, 5..9
//   PARITY : 0 = none, 1 = odd, 2 = even
//   SBITS  : stop bits per frame, 1 or 2
//   DIV    : clk cycles per UART bit, >= 1
//
// Ports:
//   clk   : system clock, all logic on posedge
//   rst   : synchronous active-high reset
//   fifo  : uart_tx_p_if.slave (data_rdy, data in; fetch out)
//   out   : UART line, idle high, registered
//   busy  : high while a frame is on the line, registered
// ---------------------------------------------------------------------------
module uart_tx_p #(
    parameter int DBITS  = 8,
    parameter int PARITY = 0,
    parameter int SBITS  = 1,
    parameter int DIV    = 1
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_p_if.slave fifo,
    output logic       out,
    output logic       busy
);

    // Divider needs to hold 0..DIV-1; DIV = 1 still gets a 1-bit counter
    // that is permanently 0, so every cycle is a tick.
    localparam int            DW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DBITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(SBITS - 1);

    // Refuse to elaborate with parameter values the frame format cannot express.
    if (DBITS < 5 || DBITS > 9) begin : g_bad_dbits
        $fatal(1, "uart_tx_p: DBITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $fatal(1, "uart_tx_p: PARITY must be 0, 1 or 2");
    end
    if (SBITS < 1 || SBITS > 2) begin : g_bad_sbits
        $fatal(1, "uart_tx_p: SBITS must be 1 or 2");
    end
    if (DIV < 1) begin : g_bad_div
        $fatal(1, "uart_tx_p: DIV must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q,   div_d;
    logic [3:0]       cnt_q,   cnt_d;
    logic [DBITS-1:0] shift_q, shift_d;
    logic             par_q,   par_d;
    logic             out_q,   out_d;
    logic             fetch_q, fetch_d;
    logic             busy_q,  busy_d;

    logic             tick;
    logic             accept;
    logic             par_calc;

    assign tick = (div_q == DIV_LAST);

    // Parity is taken from the word on the accept edge so later changes of
    // data cannot disturb the frame. With PARITY = 0 the value is unused.
    if (PARITY == 1) begin : g_par_odd
        assign par_calc = ~^fifo.data;
    end else begin : g_par_even
        assign par_calc = ^fifo.data;
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        out_d   = out_q;
        fetch_d = 1'b0;
        busy_d  = busy_q;
        accept  = 1'b0;

        // Divider free-runs 0..DIV-1 during a frame and rests at 0 in IDLE.
        if (state_q == IDLE || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end

        case (state_q)
            IDLE: begin
                if (fifo.data_rdy) begin
                    accept = 1'b1;
                end
            end

            START: begin
                if (tick) begin
                    state_d = DATA;
                    out_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = '0;
                end
            end

            // cnt_q is the index of the data bit currently on the line.
            DATA: begin
                if (tick) begin
                    if (cnt_q == LAST_DATA) begin
                        cnt_d = '0;
                        if (PARITY != 0) begin
                            state_d = PAR;
                            out_d   = par_q;
                        end else begin
                            state_d = STOP;
                            out_d   = 1'b1;
                        end
                    end else begin
                        out_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end

            PAR: begin
                if (tick) begin
                    state_d = STOP;
                    out_d   = 1'b1;
                    cnt_d   = '0;
                end
            end

            // cnt_q counts stop bits already completed; the final tick either
            // chains straight into the next frame or returns to IDLE.
            STOP: begin
                if (tick) begin
                    if (cnt_q == LAST_STOP) begin
                        if (fifo.data_rdy) begin
                            accept = 1'b1;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            out_d   = 1'b1;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                out_d   = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                div_d   = '0;
            end
        endcase

        // Accepting a word: capture it, drive the start bit and pulse fetch,
        // all on the same edge.
        if (accept) begin
            state_d = START;
            shift_d = fifo.data;
            par_d   = par_calc;
            out_d   = 1'b0;
            fetch_d = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = '0;
            div_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            out_q   <= 1'b1;
            fetch_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            out_q   <= out_d;
            fetch_q <= fetch_d;
            busy_q  <= busy_d;
        end
    end

    assign out        = out_q;
    assign busy       = busy_q;
    assign fifo.fetch = fetch_q;

endmodule

// File: tb/tb_uart_tx_p.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_p
// Self-checking bench for uart_tx_p. Four instances cover different
// parameter sets; only one is handed data_rdy at a time, the data bus and
// reset are shared.
//   0: DBITS=8 PARITY=0 SBITS=1 DIV=1
//   1: DBITS=7 PARITY=2 SBITS=1 DIV=4
//   2: DBITS=8 PARITY=1 SBITS=2 DIV=2
//   3: DBITS=5 PARITY=1 SBITS=1 DIV=3
// ---------------------------------------------------------------------------
module tb_uart_tx_p;

    logic       clk;
    logic       rst;
    logic [3:0] rdy_v;
    logic [7:0] dat_v;
    logic [3:0] out_w;
    logic [3:0] fetch_w;
    logic [3:0] busy_w;

    int errors;
    int checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_p_if #(.DBITS(8)) if_0 ();
    uart_tx_p_if #(.DBITS(7)) if_1 ();
    uart_tx_p_if #(.DBITS(8)) if_2 ();
    uart_tx_p_if #(.DBITS(5)) if_3 ();

    assign if_0.data_rdy = rdy_v[0];
    assign if_1.data_rdy = rdy_v[1];
    assign if_2.data_rdy = rdy_v[2];
    assign if_3.data_rdy = rdy_v[3];
    assign if_0.data     = dat_v;
    assign if_1.data     = dat_v[6:0];
    assign if_2.data     = dat_v;
    assign if_3.data     = dat_v[4:0];
    assign fetch_w       = {if_3.fetch, if_2.fetch, if_1.fetch, if_0.fetch};

    uart_tx_p #(.DBITS(8), .PARITY(0), .SBITS(1), .DIV(1)) dut_0 (
        .clk(clk), .rst(rst), .fifo(if_0), .out(out_w[0]), .busy(busy_w[0]));
    uart_tx_p #(.DBITS(7), .PARITY(2), .SBITS(1), .DIV(4)) dut_1 (
        .clk(clk), .rst(rst), .fifo(if_1), .out(out_w[1]), .busy(busy_w[1]));
    uart_tx_p #(.DBITS(8), .PARITY(1), .SBITS(2), .DIV(2)) dut_2 (
        .clk(clk), .rst(rst), .fifo(if_2), .out(out_w[2]), .busy(busy_w[2]));
    uart_tx_p #(.DBITS(5), .PARITY(1), .SBITS(1), .DIV(3)) dut_3 (
        .clk(clk), .rst(rst), .fifo(if_3), .out(out_w[3]), .busy(busy_w[3]));

    function automatic int p_dbits(input int k);
        case (k)
            0: return 8;
            1: return 7;
            2: return 8;
            default: return 5;
        endcase
    endfunction

    function automatic int p_parity(input int k);
        case (k)
            0: return 0;
            1: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int p_sbits(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    function automatic int p_div(input int k);
        case (k)
            0: return 1;
            1: return 4;
            2: return 2;
            default: return 3;
        endcase
    endfunction

    // Drive inputs for one clock edge, then return at the following negedge
    // where outputs are stable for sampling.
    task automatic applyStimulus(input logic r, input int k, input logic rd, input logic [7:0] d);
        rst          = r;
        rdy_v        = '0;
        rdy_v[k[1:0]] = rd;
        dat_v        = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int k, input logic e_out,
                             input logic e_fetch, input logic e_busy);
        checkOutput({tag, ".out"},   out_w[k[1:0]],   e_out);
        checkOutput({tag, ".fetch"}, fetch_w[k[1:0]], e_fetch);
        checkOutput({tag, ".busy"},  busy_w[k[1:0]],  e_busy);
    endtask

    // Single frame from idle; seq holds the expected line bits, bit i being
    // the i-th bit time. data_rdy is wiggled and data changed mid-frame, which
    // must neither produce a fetch nor alter the transmitted bits.
    task automatic check_frame(input int k, input logic [7:0] d, input logic [15:0] seq,
                               input int nbits, input string tag);
        int dv;
        int fl;
        dv = p_div(k);
        fl = nbits * dv;
        applyStimulus(1'b1, k, 1'b0, 8'h00);
        applyStimulus(1'b0, k, 1'b1, d);
        check_all($sformatf("%s[1]", tag), k, seq[0], 1'b1, 1'b1);
        for (int s = 2; s <= fl; s++) begin
            applyStimulus(1'b0, k, (s % 3) == 0, ~d);
            check_all($sformatf("%s[%0d]", tag, s), k, seq[(s - 1) / dv], 1'b0, 1'b1);
        end
        applyStimulus(1'b0, k, 1'b0, 8'h00);
        check_all($sformatf("%s[end]", tag), k, 1'b1, 1'b0, 1'b0);
    endtask

    // Random traffic against a frame-level model: each accepted word becomes
    // a list of bit values, the line is that list indexed by elapsed/DIV, and
    // a new word may only be taken when idle or in the last cycle of a frame.
    task automatic run_random(input int k, input int cycles);
        int         db, pm, sb, dv, n;
        int         m_el, m_len;
        logic       m_busy, m_fetch, p, r, rd;
        logic       m_bits [16];
        logic [7:0] d;
        logic [7:0] q [$];
        db = p_dbits(k);
        pm = p_parity(k);
        sb = p_sbits(k);
        dv = p_div(k);
        m_busy = 1'b0;
        m_el   = 0;
        m_len  = 1;
        for (int i = 0; i < 16; i++) m_bits[i] = 1'b1;
        applyStimulus(1'b1, k, 1'b0, 8'h00);
        for (int c = 0; c < cycles; c++) begin
            if (q.size() < 2) q.push_back(8'($urandom));
            r  = ($urandom_range(0, 199) == 0);
            rd = ($urandom_range(0, 3) != 0);
            d  = rd ? q[0] : 8'($urandom);
            applyStimulus(r, k, rd, d);
            m_fetch = 1'b0;
            if (r) begin
                m_busy = 1'b0;
            end else if (!m_busy || m_el == m_len - 1) begin
                if (rd) begin
                    n = 0;
                    p = 1'b0;
                    m_bits[n] = 1'b0;
                    n++;
                    for (int i = 0; i < db; i++) begin
                        m_bits[n] = d[i];
                        p = p ^ d[i];
                        n++;
                    end
                    if (pm != 0) begin
                        m_bits[n] = (pm == 1) ? ~p : p;
                        n++;
                    end
                    for (int s = 0; s < sb; s++) begin
                        m_bits[n] = 1'b1;
                        n++;
                    end
                    m_len   = n * dv;
                    m_el    = 0;
                    m_busy  = 1'b1;
                    m_fetch = 1'b1;
                    void'(q.pop_front());
                end else begin
                    m_busy = 1'b0;
                end
            end else begin
                m_el++;
            end
            check_all($sformatf("rnd%0d[%0d]", k, c), k,
                      m_busy ? m_bits[m_el / dv] : 1'b1, m_fetch, m_busy);
        end
    endtask

    typedef struct packed {
        logic       rst;
        logic       rdy;
        logic [7:0] data;
        logic       exp_out;
        logic       exp_fetch;
        logic       exp_busy;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [19:0] seq_b2b;
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        rdy_v  = '0;
        dat_v  = '0;

        //            rst   rdy   data   out   fetch busy
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

        @(negedge clk);

        // 0xA5 on the default instance, ignored data_rdy mid-frame, then a
        // second accept aborted by reset.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i].rst, 0, tbl[i].rdy, tbl[i].data);
            check_all($sformatf("tbl[%0d]", i), 0, tbl[i].exp_out,
                      tbl[i].exp_fetch, tbl[i].exp_busy);
        end

        $display("[TB] single frames");
        check_frame(1, 8'h41, 16'b0000_0010_1000_0010, 10, "b41");
        check_frame(2, 8'h00, 16'b0000_1110_0000_0000, 12, "c00");
        check_frame(3, 8'h13, 16'b0000_0000_1010_0110, 8,  "d13");

        // Back-to-back 0x55 then 0x0F with data_rdy held high.
        $display("[TB] back-to-back");
        seq_b2b = 20'b1000011110_1010101010;
        applyStimulus(1'b1, 0, 1'b0, 8'h00);
        for (int s = 1; s <= 20; s++) begin
            applyStimulus(1'b0, 0, s <= 11, (s == 1) ? 8'h55 : 8'h0F);
            check_all($sformatf("b2b[%0d]", s), 0, seq_b2b[s - 1],
                      (s == 1) || (s == 11), 1'b1);
        end
        applyStimulus(1'b0, 0, 1'b0, 8'h00);
        check_all("b2b[end]", 0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of DATA on the DIV=3 instance.
        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 3, 1'b0, 8'h00);
        applyStimulus(1'b0, 3, 1'b1, 8'h00);
        check_all("rst[1]", 3, 1'b0, 1'b1, 1'b1);
        for (int s = 2; s <= 10; s++) begin
            applyStimulus(1'b0, 3, 1'b0, 8'h00);
            check_all($sformatf("rst[%0d]", s), 3, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b1, 3, 1'b0, 8'h00);
        check_all("rst[hit]", 3, 1'b1, 1'b0, 1'b0);
        for (int s = 0; s < 6; s++) begin
            applyStimulus(1'b0, 3, 1'b0, 8'h00);
            check_all($sformatf("rst[idle%0d]", s), 3, 1'b1, 1'b0, 1'b0);
        end

        $display("[TB] random traffic");
        for (int k = 0; k < 4; k++) begin
            run_random(k, 600);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
